// File: rtl/hist_phase_sequencer.sv
// Phase sequencer for the two-image histogram-equalization pipeline: clear,
// histogram, CDF and remap passes per image, with paired input-SRAM read addresses.
module hist_phase_sequencer #(
  parameter int AddressSize = 16,
  parameter int Img0Base    = 0,
  parameter int Img0Words   = 19200,
  parameter int Img1Base    = 32768,
  parameter int Img1Words   = 19200
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   StartSignal,
  input  logic                   Stall,
  input  logic                   ClearDone,
  input  logic                   HistDone,
  input  logic                   CdfDone,
  input  logic                   MapDone,
  output logic [AddressSize-1:0] ReadAddressInput_1,
  output logic [AddressSize-1:0] ReadAddressInput_2,
  output logic                   AddrValid,
  output logic                   PassSelect,
  output logic                   ImageSel,
  output logic                   ClearStart,
  output logic                   CdfStart,
  output logic                   Busy,
  output logic [1:0]             GlobalFlag
);

  localparam logic [AddressSize-1:0] BASE0 = AddressSize'(Img0Base);
  localparam logic [AddressSize-1:0] BASE1 = AddressSize'(Img1Base);
  localparam logic [AddressSize-1:0] LAST0 = AddressSize'(Img0Words / 2 - 1);
  localparam logic [AddressSize-1:0] LAST1 = AddressSize'(Img1Words / 2 - 1);
  localparam logic [AddressSize-1:0] STEP  = AddressSize'(2);
  localparam logic [AddressSize-1:0] ONE   = AddressSize'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_HIST, S_HDRAIN, S_CDF, S_MAP, S_MDRAIN, S_NEXT, S_DONE
  } state_t;

  state_t                 state, state_nx;
  logic [AddressSize-1:0] pair_cnt, pair_cnt_nx;
  logic [AddressSize-1:0] addr1_nx, addr2_nx;
  logic [AddressSize-1:0] base_sel, last_sel;
  logic                   valid_nx, pass_nx, image_nx, clear_start_nx, cdf_start_nx, busy_nx;
  logic [1:0]             flag_nx;

  assign base_sel = ImageSel ? BASE1 : BASE0;
  assign last_sel = ImageSel ? LAST1 : LAST0;

  // Handshake: a pair is consumed on any cycle with AddrValid=1 and Stall=0;
  // with Stall=1 the presented pair and AddrValid stay frozen.
  always_comb begin
    state_nx       = state;
    pair_cnt_nx    = pair_cnt;
    addr1_nx       = ReadAddressInput_1;
    valid_nx       = AddrValid;
    pass_nx        = PassSelect;
    image_nx       = ImageSel;
    flag_nx        = GlobalFlag;
    clear_start_nx = 1'b0;
    cdf_start_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (StartSignal) begin
          state_nx       = S_CLEAR;
          clear_start_nx = 1'b1;
          flag_nx        = 2'b00;
          image_nx       = 1'b0;
        end
      end
      // ClearStart/CdfStart are high only on the entry cycle, so masking with
      // them drops a done pulse that coincides with its own start.
      S_CLEAR: begin
        if (ClearDone && !ClearStart) begin
          state_nx    = S_HIST;
          valid_nx    = 1'b1;
          pass_nx     = 1'b0;
          addr1_nx    = base_sel;
          pair_cnt_nx = '0;
        end
      end
      S_HIST, S_MAP: begin
        if (!Stall) begin
          if (pair_cnt == last_sel) begin
            state_nx = (state == S_HIST) ? S_HDRAIN : S_MDRAIN;
            valid_nx = 1'b0;
          end else begin
            pair_cnt_nx = pair_cnt + ONE;
            addr1_nx    = ReadAddressInput_1 + STEP;
          end
        end
      end
      S_HDRAIN: begin
        if (HistDone) begin
          state_nx     = S_CDF;
          cdf_start_nx = 1'b1;
        end
      end
      S_CDF: begin
        if (CdfDone && !CdfStart) begin
          state_nx    = S_MAP;
          valid_nx    = 1'b1;
          pass_nx     = 1'b1;
          addr1_nx    = base_sel;
          pair_cnt_nx = '0;
        end
      end
      S_MDRAIN: begin
        if (MapDone) state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (!ImageSel) begin
          state_nx       = S_CLEAR;
          clear_start_nx = 1'b1;
          flag_nx        = 2'b01;
          image_nx       = 1'b1;
        end else begin
          state_nx = S_DONE;
          flag_nx  = 2'b10;
        end
      end
      S_DONE: begin
        if (!StartSignal) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    addr2_nx = addr1_nx + ONE;
    busy_nx  = !(state_nx == S_IDLE || state_nx == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= S_IDLE;
      pair_cnt           <= '0;
      ReadAddressInput_1 <= '0;
      ReadAddressInput_2 <= '0;
      AddrValid          <= 1'b0;
      PassSelect         <= 1'b0;
      ImageSel           <= 1'b0;
      ClearStart         <= 1'b0;
      CdfStart           <= 1'b0;
      Busy               <= 1'b0;
      GlobalFlag         <= 2'b00;
    end else begin
      state              <= state_nx;
      pair_cnt           <= pair_cnt_nx;
      ReadAddressInput_1 <= addr1_nx;
      ReadAddressInput_2 <= addr2_nx;
      AddrValid          <= valid_nx;
      PassSelect         <= pass_nx;
      ImageSel           <= image_nx;
      ClearStart         <= clear_start_nx;
      CdfStart           <= cdf_start_nx;
      Busy               <= busy_nx;
      GlobalFlag         <= flag_nx;
    end
  end

endmodule

// File: tb/tb_hist_phase_sequencer.sv
// Bench for hist_phase_sequencer: a small-image instance and an address-wrap
// instance share stimulus; address pairs are scored against an expected queue.
module tb_hist_phase_sequencer;
  localparam int AW = 16;

  logic clock = 1'b0, reset = 1'b1, StartSignal = 1'b0, Stall = 1'b0;
  logic clear_auto = 1'b0, hist_auto = 1'b0, cdf_auto = 1'b0, map_auto = 1'b0;
  logic hist_man = 1'b0, map_man = 1'b0;
  logic ClearDone, HistDone, CdfDone, MapDone;
  assign ClearDone = clear_auto;
  assign HistDone  = hist_auto | hist_man;
  assign CdfDone   = cdf_auto;
  assign MapDone   = map_auto | map_man;

  logic [AW-1:0] a_rd1, a_rd2, w_rd1, w_rd2;
  logic a_valid, a_pass, a_img, a_clr, a_cdf, a_busy;
  logic w_valid, w_pass, w_img, w_clr, w_cdf, w_busy;
  logic [1:0] a_flag, w_flag;
  logic [39:0] a_outs, w_outs;
  assign a_outs = {a_rd1, a_rd2, a_valid, a_pass, a_img, a_clr, a_cdf, a_busy, a_flag};
  assign w_outs = {w_rd1, w_rd2, w_valid, w_pass, w_img, w_clr, w_cdf, w_busy, w_flag};

  hist_phase_sequencer #(.AddressSize(AW), .Img0Base(0), .Img0Words(4),
                         .Img1Base(32768), .Img1Words(6)) dut_a (
    .clock(clock), .reset(reset), .StartSignal(StartSignal), .Stall(Stall),
    .ClearDone(ClearDone), .HistDone(HistDone), .CdfDone(CdfDone), .MapDone(MapDone),
    .ReadAddressInput_1(a_rd1), .ReadAddressInput_2(a_rd2), .AddrValid(a_valid),
    .PassSelect(a_pass), .ImageSel(a_img), .ClearStart(a_clr), .CdfStart(a_cdf),
    .Busy(a_busy), .GlobalFlag(a_flag));

  hist_phase_sequencer #(.AddressSize(AW), .Img0Base(0), .Img0Words(4),
                         .Img1Base(65534), .Img1Words(4)) dut_w (
    .clock(clock), .reset(reset), .StartSignal(StartSignal), .Stall(Stall),
    .ClearDone(ClearDone), .HistDone(HistDone), .CdfDone(CdfDone), .MapDone(MapDone),
    .ReadAddressInput_1(w_rd1), .ReadAddressInput_2(w_rd2), .AddrValid(w_valid),
    .PassSelect(w_pass), .ImageSel(w_img), .ClearStart(w_clr), .CdfStart(w_cdf),
    .Busy(w_busy), .GlobalFlag(w_flag));

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  // scoreboard state
  logic [33:0] exp_a_q[$];
  logic [33:0] exp_w_q[$];
  int n_checks = 0, n_errors = 0;
  int a_cyc[4];
  int w_cyc[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_img(input bit to_w, input bit img, input int base, input int words);
    logic [33:0] e;
    logic [AW-1:0] x1, x2;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < words / 2; k++) begin
        x1 = AW'((base + 2 * k) % 65536);
        x2 = AW'((base + 2 * k + 1) % 65536);
        e = {img, (p == 1), x1, x2};
        if (to_w) exp_w_q.push_back(e);
        else exp_a_q.push_back(e);
      end
    end
  endtask

  task automatic push_run();
    push_img(1'b0, 1'b0, 0, 4);
    push_img(1'b0, 1'b1, 32768, 6);
    push_img(1'b1, 1'b0, 0, 4);
    push_img(1'b1, 1'b1, 65534, 4);
  endtask

  task automatic clear_cyc();
    for (int i = 0; i < 4; i++) begin
      a_cyc[i] = 0;
      w_cyc[i] = 0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!a_valid && n < 100) begin
      tick();
      n++;
    end
    check("wait_valid", a_valid, 1'b1);
  endtask

  task automatic wait_flag(input logic [1:0] f, input string tag);
    int n = 0;
    while (a_flag !== f && n < 400) begin
      tick();
      n++;
    end
    check(tag, a_flag, f);
  endtask

  // monitors: compare each presented pair, pop only on acceptance
  always @(negedge clock) begin
    if (a_valid) begin
      a_cyc[{a_img, a_pass}]++;
      check("a_q_nonempty", exp_a_q.size() != 0, 1'b1);
      if (exp_a_q.size() != 0) begin
        check("a_pair", {a_img, a_pass, a_rd1, a_rd2}, exp_a_q[0]);
        if (!Stall) void'(exp_a_q.pop_front());
      end
    end
    if (w_valid) begin
      w_cyc[{w_img, w_pass}]++;
      check("w_q_nonempty", exp_w_q.size() != 0, 1'b1);
      if (exp_w_q.size() != 0) begin
        check("w_pair", {w_img, w_pass, w_rd1, w_rd2}, exp_w_q[0]);
        if (!Stall) void'(exp_w_q.pop_front());
      end
    end
  end

  // done responder: pulse two cycles after each start or drain entry of dut_a
  int clr_cnt = 0, hist_cnt = 0, cdf_cnt = 0, map_cnt = 0;
  logic prev_valid = 1'b0;
  always begin
    tick();
    clear_auto = (clr_cnt == 1);
    hist_auto  = (hist_cnt == 1);
    cdf_auto   = (cdf_cnt == 1);
    map_auto   = (map_cnt == 1);
    if (clr_cnt != 0) clr_cnt--;
    if (hist_cnt != 0) hist_cnt--;
    if (cdf_cnt != 0) cdf_cnt--;
    if (map_cnt != 0) map_cnt--;
    if (a_clr) clr_cnt = 2;
    if (a_cdf) cdf_cnt = 2;
    if (prev_valid && !a_valid) begin
      if (a_pass) map_cnt = 2;
      else hist_cnt = 2;
    end
    prev_valid = a_valid;
  end

  // driver
  initial begin
    int n;
    reset = 1'b1;
    tick();
    tick();
    check("reset_outs_a", a_outs, 40'd0);
    check("reset_outs_w", w_outs, 40'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", a_busy, 1'b0);

    // run 1: spurious dones in CLEAR/HIST, stall on pair 1 of image 0 HIST
    clear_cyc();
    push_run();
    StartSignal = 1'b1;
    tick();
    check("start_clr", {a_clr, a_busy, a_flag, a_img}, 5'b11000);
    hist_man = 1'b1;
    map_man  = 1'b1;
    tick();
    hist_man = 1'b0;
    map_man  = 1'b0;
    check("spur_clear", {a_cdf, a_valid, a_busy, a_clr}, 4'b0010);
    wait_valid(n);
    map_man = 1'b1;
    tick();
    map_man = 1'b0;
    Stall = 1'b1;
    tick();
    tick();
    tick();
    Stall = 1'b0;
    wait_flag(2'b01, "flag01");
    check("clr_with_flag01", {a_clr, a_img}, 2'b11);
    wait_flag(2'b10, "flag10");
    check("done_outs", {a_busy, w_busy, w_flag}, 4'b0010);
    check("hist0_cycles", a_cyc[0], 5);
    check("map0_cycles", a_cyc[1], 2);
    check("hist1_cycles", a_cyc[2], 3);
    check("map1_cycles", a_cyc[3], 3);
    check("w_hist1_cycles", w_cyc[2], 2);
    check("a_q_drained", exp_a_q.size(), 0);
    check("w_q_drained", exp_w_q.size(), 0);

    // held start keeps DONE; lower then raise restarts
    for (int i = 0; i < 6; i++) begin
      tick();
      check("done_hold", {a_flag, a_busy, a_clr}, 4'b1000);
    end
    StartSignal = 1'b0;
    tick();
    tick();
    check("idle_keeps_flag", {a_flag, a_busy}, 3'b100);
    clear_cyc();
    push_run();
    StartSignal = 1'b1;
    tick();
    check("restart", {a_clr, a_busy, a_flag, a_img}, 5'b11000);
    tick();
    check("clr_one_cycle", a_clr, 1'b0);

    // run 2: reset in the middle of image 1 MAP
    n = 0;
    while (!(a_valid && a_pass && a_img) && n < 300) begin
      tick();
      n++;
    end
    check("reach_map1", {a_valid, a_pass, a_img}, 3'b111);
    tick();
    reset = 1'b1;
    StartSignal = 1'b0;
    tick();
    check("midreset_a", a_outs, 40'd0);
    check("midreset_w", w_outs, 40'd0);
    reset = 1'b0;
    exp_a_q.delete();
    exp_w_q.delete();
    clear_cyc();
    push_run();
    tick();
    StartSignal = 1'b1;
    tick();
    check("fresh_start", {a_clr, a_busy, a_flag, a_img}, 5'b11000);
    wait_valid(n);
    check("clear_to_valid", n, 3);
    check("first_addr", {a_rd1, a_rd2}, {16'd0, 16'd1});
    wait_flag(2'b01, "flag01_r3");
    wait_flag(2'b10, "flag10_r3");
    check("end_outs", {a_busy, a_img, w_flag, w_img}, 5'b01101);
    check("hist0_nostall", a_cyc[0], 2);
    check("a_q_drained_r3", exp_a_q.size(), 0);
    check("w_q_drained_r3", exp_w_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hist_phase_sequencer.md
# hist_phase_sequencer

Top-level phase controller for the histogram-equalization pipeline. It runs two images back-to-back: image 0 at input SRAM base 0 and image 1 at base 32768. For each image it sequences four passes: scratch clear, histogram, CDF and remap. During the histogram and remap passes it generates the paired read addresses for the input SRAM's two read ports. It reports completion to the control block on the 2-bit `GlobalFlag`.

## Interface
Parameters:
- `AddressSize`, 16, width of SRAM word addresses.
- `Img0Base`, 0, first input word of image 0.
- `Img0Words`, 19200, 128-bit words in image 0; must be even and ≥2.
- `Img1Base`, 32768, first input word of image 1.
- `Img1Words`, 19200, 128-bit words in image 1; must be even and ≥2.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `StartSignal` in 1: level start request from control.
- `Stall` in 1: datapath cannot accept the presented address pair this cycle.
- `ClearDone` in 1: one-cycle pulse, scratch histogram clear finished.
- `HistDone` in 1: one-cycle pulse, histogram pipeline drained.
- `CdfDone` in 1: one-cycle pulse, CDF/LUT build finished.
- `MapDone` in 1: one-cycle pulse, remap pipeline drained, last output word written.
- `ReadAddressInput_1` out `AddressSize`: even word address of the current pair.
- `ReadAddressInput_2` out `AddressSize`: odd word address, always `ReadAddressInput_1`+1.
- `AddrValid` out 1: address pair is valid.
- `PassSelect` out 1: 0 = histogram pass, 1 = remap pass; meaningful while `AddrValid`=1.
- `ImageSel` out 1: image currently being processed.
- `ClearStart` out 1: one-cycle pulse, starts the scratch clear.
- `CdfStart` out 1: one-cycle pulse, starts the CDF build.
- `Busy` out 1: high in every state except IDLE and DONE.
- `GlobalFlag` out 2: 00 = none done, 01 = image 0 done, 10 = both done.

## Operation
- All outputs are registered.
- Reset value of every output is 0. State is IDLE and `ImageSel` is 0.
- States (9):
  - IDLE: if `StartSignal`=1, go to CLEAR, set `GlobalFlag`=00 and `ImageSel`=0.
  - CLEAR: assert `ClearStart` on the entry cycle only. Go to HIST on `ClearDone`.
  - HIST: issue address pairs with `PassSelect`=0. After the last pair is accepted, go to HDRAIN.
  - HDRAIN: go to CDF on `HistDone`.
  - CDF: assert `CdfStart` on the entry cycle only. Go to MAP on `CdfDone`.
  - MAP: issue address pairs with `PassSelect`=1. After the last pair is accepted, go to MDRAIN.
  - MDRAIN: go to NEXT on `MapDone`.
  - NEXT (one cycle):
    - If `ImageSel`=0: set `GlobalFlag`=01, set `ImageSel`=1, go to CLEAR.
    - Otherwise: set `GlobalFlag`=10, go to DONE.
  - DONE: hold `GlobalFlag`. When `StartSignal`=0, go to IDLE. A held-high start therefore never re-triggers.
- Address generation:
  - Pair k is `ReadAddressInput_1` = base+2k and `ReadAddressInput_2` = base+2k+1, for k = 0 … Words/2−1.
  - base/Words are `Img0Base`/`Img0Words` when `ImageSel`=0, else `Img1Base`/`Img1Words`.
- A pair is accepted in a cycle with `AddrValid`=1 and `Stall`=0.
- While `Stall`=1, address and `AddrValid` hold unchanged.
- The pair counter is `AddressSize` bits. The address adder is `AddressSize` bits and wraps modulo 2^`AddressSize` (no saturation).
- Done pulses are honored only in their matching wait state:
  - A done pulse arriving in any other state is ignored and is not remembered.
  - A done pulse coincident with the corresponding start pulse is ignored.
- `Stall` is ignored outside HIST/MAP.
- `GlobalFlag` holds 01 for the whole of image 1 processing. It returns to 00 only on a new start from IDLE or on reset.

## Timing
- `StartSignal` sampled high in IDLE at edge t gives `ClearStart`=1 and `Busy`=1 in cycle t+1.
- Done pulse sampled at edge t in a wait state gives the next state's outputs in cycle t+1:
  - `ClearDone` → `AddrValid`=1 with pair 0.
  - `CdfDone` → `AddrValid`=1 with pair 0.
  - `HistDone` → `CdfStart`=1.
- HIST/MAP with no stalls last exactly Words/2 cycles of `AddrValid`. `AddrValid` is 0 in the cycle after the last acceptance.
- NEXT is one cycle.
  - After image 0: `GlobalFlag`=01 and `ClearStart`=1 appear together in the cycle after NEXT.
  - After image 1: `GlobalFlag`=10 and `Busy`=0 appear in the cycle after NEXT.
- Reset asserted in any state: all outputs are 0 and state is IDLE on the following cycle; the pass in progress is abandoned.
- Minimum image latency with zero-latency done responses is 2·(Words/2) + 7 cycles.

## Test plan
- Image-size override: `Img0Words`=4, `Img1Words`=6, `Img1Base`=32768, done pulses returned 2 cycles after each start or drain entry.
  - Required: pairs (0,1),(2,3) for HIST then MAP of image 0.
  - Required: `GlobalFlag`=01, then pairs (32768,32769)…(32772,32773) twice.
  - Required: `GlobalFlag`=10, `Busy`=0, `StartSignal` held high keeps the block in DONE.
- Stall: `Stall` high for 3 cycles on pair 1 of image 0 HIST → (2,3) held with `AddrValid`=1 for 4 cycles; total HIST `AddrValid` cycles = 5.
- Spurious dones: `MapDone` pulsed during CLEAR and HIST, `HistDone` pulsed during CLEAR → no state change; the later correct `HistDone` still advances to CDF.
- Reset mid-MAP of image 1 → next cycle all outputs 0, `GlobalFlag`=00; a fresh `StartSignal` restarts image 0 at address 0.
- Wrap: `Img1Base`=65534, `Img1Words`=4 → pairs (65534,65535) then (0,1).
- Restart: `StartSignal` lowered in DONE, then raised → `GlobalFlag` returns to 00 and `ClearStart` pulses one cycle after the rise is sampled.
